// File: rtl/branch_rs.sv
// Branch reservation station: holds conditional branches until both operands are
// present, then issues the oldest ready one per cycle to an external comparator.
module branch_rs #(
  parameter int ENTRIES = 4,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [9:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [31:0]      in_vj,
  input  logic [31:0]      in_vk,
  input  logic [TAG_W-1:0] in_qj,
  input  logic [TAG_W-1:0] in_qk,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_imm,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_value,
  input  logic             flush,
  output logic [31:0]      br_vj,
  output logic [31:0]      br_vk,
  output logic [9:0]       br_op,
  input  logic             br_y,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_taken,
  output logic [31:0]      out_target
);

  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  logic [ENTRIES-1:0] r_busy;
  logic [9:0]         r_op  [ENTRIES];
  logic [TAG_W-1:0]   r_tag [ENTRIES];
  logic [31:0]        r_vj  [ENTRIES];
  logic [31:0]        r_vk  [ENTRIES];
  logic [TAG_W-1:0]   r_qj  [ENTRIES];
  logic [TAG_W-1:0]   r_qk  [ENTRIES];
  logic [31:0]        r_pc  [ENTRIES];
  logic [31:0]        r_imm [ENTRIES];
  // r_older[i][j] == 1 means entry i was inserted before entry j.
  logic [ENTRIES-1:0] r_older [ENTRIES];

  logic             r_out_valid;
  logic [TAG_W-1:0] r_out_tag;
  logic             r_out_taken;
  logic [31:0]      r_out_target;

  logic [ENTRIES-1:0] w_ready;
  logic [ENTRIES-1:0] w_grant;
  logic               w_sel_valid;
  logic [IDX_W-1:0]   w_sel_idx;
  logic [IDX_W-1:0]   w_free_idx;
  logic               w_full;
  logic               w_ins;
  logic               w_byp_j;
  logic               w_byp_k;
  logic [31:0]        w_sel_pc;
  logic [31:0]        w_sel_imm;
  logic [31:0]        w_target;

  // Insert handshake: a branch is taken on any edge where in_valid && in_ready.
  // in_ready looks only at registered occupancy, so a slot freed by this
  // cycle's dispatch is not offered until the following cycle.
  assign w_full   = &r_busy;
  assign in_ready = !w_full;
  assign w_ins    = in_valid && !w_full;
  assign w_byp_j  = cdb_valid && (in_qj != '0) && (in_qj == cdb_tag);
  assign w_byp_k  = cdb_valid && (in_qk != '0) && (in_qk == cdb_tag);

  always_comb begin
    w_free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!r_busy[i]) w_free_idx = IDX_W'(i);
    end
  end

  // An entry wins when no other ready entry is older than it.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      w_ready[i] = r_busy[i] && (r_qj[i] == '0) && (r_qk[i] == '0);
    end
    for (int i = 0; i < ENTRIES; i++) begin
      w_grant[i] = w_ready[i];
      for (int j = 0; j < ENTRIES; j++) begin
        if (j != i && w_ready[j] && r_older[j][i]) w_grant[i] = 1'b0;
      end
    end
  end

  always_comb begin
    w_sel_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (w_grant[i]) w_sel_idx = IDX_W'(i);
    end
  end

  assign w_sel_valid = |w_grant;
  assign br_vj       = w_sel_valid ? r_vj[w_sel_idx] : '0;
  assign br_vk       = w_sel_valid ? r_vk[w_sel_idx] : '0;
  assign br_op       = w_sel_valid ? r_op[w_sel_idx] : '0;
  assign w_sel_pc    = r_pc[w_sel_idx];
  assign w_sel_imm   = r_imm[w_sel_idx];
  assign w_target    = br_y ? (w_sel_pc + w_sel_imm) : (w_sel_pc + 32'd4);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy       <= '0;
      r_out_valid  <= 1'b0;
      r_out_tag    <= '0;
      r_out_taken  <= 1'b0;
      r_out_target <= '0;
      for (int i = 0; i < ENTRIES; i++) r_older[i] <= '0;
    end else if (flush) begin
      r_busy      <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= w_sel_valid;
      if (w_sel_valid) begin
        r_out_tag    <= r_tag[w_sel_idx];
        r_out_taken  <= br_y;
        r_out_target <= w_target;
      end
      for (int i = 0; i < ENTRIES; i++) begin
        if (cdb_valid && r_busy[i] && (r_qj[i] != '0) && (r_qj[i] == cdb_tag)) begin
          r_vj[i] <= cdb_value;
          r_qj[i] <= '0;
        end
        if (cdb_valid && r_busy[i] && (r_qk[i] != '0) && (r_qk[i] == cdb_tag)) begin
          r_vk[i] <= cdb_value;
          r_qk[i] <= '0;
        end
        if (w_grant[i]) r_busy[i] <= 1'b0;
        if (w_ins && (w_free_idx == IDX_W'(i))) begin
          r_busy[i]  <= 1'b1;
          r_op[i]    <= in_op;
          r_tag[i]   <= in_tag;
          r_pc[i]    <= in_pc;
          r_imm[i]   <= in_imm;
          r_vj[i]    <= w_byp_j ? cdb_value : in_vj;
          r_qj[i]    <= w_byp_j ? '0 : in_qj;
          r_vk[i]    <= w_byp_k ? cdb_value : in_vk;
          r_qk[i]    <= w_byp_k ? '0 : in_qk;
          r_older[i] <= '0;
        end else if (w_ins) begin
          r_older[i][w_free_idx] <= 1'b1;
        end
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_tag    = r_out_tag;
  assign out_taken  = r_out_taken;
  assign out_target = r_out_target;

endmodule

// File: tb/tb_branch_rs.sv
// Self-checking bench for branch_rs: comparator model, expected-result queue
// filled at stimulus time and drained by a monitor on out_valid.
module tb_branch_rs;

  localparam int TAG_W = 4;
  localparam int RW    = TAG_W + 1 + 32;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [9:0]       in_op;
  logic [TAG_W-1:0] in_tag;
  logic [31:0]      in_vj;
  logic [31:0]      in_vk;
  logic [TAG_W-1:0] in_qj;
  logic [TAG_W-1:0] in_qk;
  logic [31:0]      in_pc;
  logic [31:0]      in_imm;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_value;
  logic             flush;
  logic [31:0]      br_vj;
  logic [31:0]      br_vk;
  logic [9:0]       br_op;
  logic             br_y;
  logic             out_valid;
  logic [TAG_W-1:0] out_tag;
  logic             out_taken;
  logic [31:0]      out_target;

  logic [RW-1:0] exp_q[$];
  int n_checks;
  int n_fail;

  branch_rs #(.ENTRIES(4), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_tag(in_tag),
    .in_vj(in_vj), .in_vk(in_vk), .in_qj(in_qj), .in_qk(in_qk),
    .in_pc(in_pc), .in_imm(in_imm),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .flush(flush),
    .br_vj(br_vj), .br_vk(br_vk), .br_op(br_op), .br_y(br_y),
    .out_valid(out_valid), .out_tag(out_tag), .out_taken(out_taken),
    .out_target(out_target)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // comparator model
  function automatic logic cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) < $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  assign br_y = cond(br_op[9:7], br_vj, br_vk);

  function automatic logic [RW-1:0] mk_exp(input logic [TAG_W-1:0] tag, input logic [2:0] f3,
                                           input logic [31:0] vj, input logic [31:0] vk,
                                           input logic [31:0] pc, input logic [31:0] imm);
    logic t;
    t = cond(f3, vj, vk);
    return {tag, t, t ? pc + imm : pc + 32'd4};
  endfunction

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    in_op     = '0;
    in_tag    = '0;
    in_vj     = '0;
    in_vk     = '0;
    in_qj     = '0;
    in_qk     = '0;
    in_pc     = '0;
    in_imm    = '0;
    cdb_valid = 1'b0;
    cdb_tag   = '0;
    cdb_value = '0;
    flush     = 1'b0;
  endtask

  task automatic drive_ins(input logic [2:0] f3, input logic [TAG_W-1:0] tag,
                           input logic [31:0] vj, input logic [TAG_W-1:0] qj,
                           input logic [31:0] vk, input logic [TAG_W-1:0] qk,
                           input logic [31:0] pc, input logic [31:0] imm);
    in_valid = 1'b1;
    in_op    = {f3, 7'h63};
    in_tag   = tag;
    in_vj    = vj;
    in_qj    = qj;
    in_vk    = vk;
    in_qk    = qk;
    in_pc    = pc;
    in_imm   = imm;
  endtask

  task automatic drive_cdb(input logic [TAG_W-1:0] tag, input logic [31:0] value);
    cdb_valid = 1'b1;
    cdb_tag   = tag;
    cdb_value = value;
  endtask

  task automatic wait_drain(input int max_cycles, output int left);
    for (int c = 0; c < max_cycles && exp_q.size() != 0; c++) step();
    left = exp_q.size();
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_out: got tag=%0d taken=%0b target=%h, required no result",
                 out_tag, out_taken, out_target);
      end else begin
        logic [RW-1:0] e;
        e = exp_q.pop_front();
        if ({out_tag, out_taken, out_target} !== e) begin
          n_fail++;
          $display("FAIL result: got tag=%0d taken=%0b target=%h, required tag=%0d taken=%0b target=%h",
                   out_tag, out_taken, out_target, e[RW-1 -: TAG_W], e[32], e[31:0]);
        end
      end
    end
  end

  task automatic test_reset();
    idle();
    reset = 1'b1;
    step();
    step();
    n_checks++;
    if ({out_valid, out_tag, out_taken, out_target} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0", {out_valid, out_tag, out_taken, out_target});
    end
    n_checks++;
    if (in_ready !== 1'b1 || {br_vj, br_vk, br_op} !== '0) begin
      n_fail++;
      $display("FAIL reset_idle: got in_ready=%b br_op=%h, required in_ready=1 br_op=0", in_ready, br_op);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_beq_ready();
    drive_ins(3'b000, 4'd1, 32'd5, 4'd0, 32'd5, 4'd0, 32'h100, 32'h20);
    exp_q.push_back(mk_exp(4'd1, 3'b000, 32'd5, 32'd5, 32'h100, 32'h20));
    step();
    idle();
    n_checks++;
    if (out_valid !== 1'b0 || br_op !== {3'b000, 7'h63} || br_vj !== 32'd5) begin
      n_fail++;
      $display("FAIL beq_select: got out_valid=%b br_op=%h br_vj=%h, required 0/%h/5",
               out_valid, br_op, br_vj, {3'b000, 7'h63});
    end
    step();
    n_checks++;
    if (out_valid !== 1'b1 || out_taken !== 1'b1 || out_target !== 32'h120) begin
      n_fail++;
      $display("FAIL beq_latency: got valid=%b taken=%b target=%h, required 1/1/00000120",
               out_valid, out_taken, out_target);
    end
  endtask

  task automatic test_blt_wakeup();
    drive_ins(3'b100, 4'd2, 32'd0, 4'd3, 32'd0, 4'd0, 32'h200, 32'h40);
    step();
    idle();
    n_checks++;
    if (br_op !== 10'd0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL blt_waiting: got br_op=%h out_valid=%b, required 0/0", br_op, out_valid);
    end
    drive_cdb(4'd3, 32'hFFFF_FFFF);
    step();
    idle();
    exp_q.push_back(mk_exp(4'd2, 3'b100, 32'hFFFF_FFFF, 32'd0, 32'h200, 32'h40));
    n_checks++;
    if (out_valid !== 1'b0 || br_vj !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL blt_capture: got out_valid=%b br_vj=%h, required 0/ffffffff", out_valid, br_vj);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b1 || out_taken !== 1'b1 || out_target !== 32'h240) begin
      n_fail++;
      $display("FAIL blt_dispatch: got valid=%b taken=%b target=%h, required 1/1/00000240",
               out_valid, out_taken, out_target);
    end
  endtask

  task automatic test_age_order();
    int left;
    drive_ins(3'b001, 4'd4, 32'd0, 4'd8,  32'd7,          4'd0, 32'h1000,      32'h10);
    step();
    drive_ins(3'b101, 4'd5, 32'd0, 4'd9,  32'hFFFF_FFFF,  4'd0, 32'h2000,      32'h10);
    step();
    drive_ins(3'b110, 4'd6, 32'd0, 4'd10, 32'h8000_0000,  4'd0, 32'h3000,      32'hFFFF_FFF0);
    step();
    drive_ins(3'b011, 4'd7, 32'd0, 4'd11, 32'd5,          4'd0, 32'hFFFF_FFFC, 32'h10);
    step();
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_ready: got in_ready=%b required 0", in_ready);
    end
    drive_ins(3'b000, 4'd12, 32'd0, 4'd0, 32'd0, 4'd0, 32'h9000, 32'h0);
    step();
    idle();
    n_checks++;
    if (in_ready !== 1'b0 || br_op !== 10'd0) begin
      n_fail++;
      $display("FAIL full_reject: got in_ready=%b br_op=%h, required 0/0", in_ready, br_op);
    end
    drive_cdb(4'd10, 32'd1);
    exp_q.push_back(mk_exp(4'd6, 3'b110, 32'd1, 32'h8000_0000, 32'h3000, 32'hFFFF_FFF0));
    step();
    drive_cdb(4'd8, 32'd7);
    exp_q.push_back(mk_exp(4'd4, 3'b001, 32'd7, 32'd7, 32'h1000, 32'h10));
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL freeing_ready: got in_ready=%b required 0", in_ready);
    end
    step();
    idle();
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL freed_ready: got in_ready=%b required 1", in_ready);
    end
    wait_drain(6, left);
    n_checks++;
    if (left !== 0) begin
      n_fail++;
      $display("FAIL wake_drain: got %0d pending, required 0", left);
    end
    // Young entry at low index competes with older entries at higher indices.
    drive_ins(3'b111, 4'd12, 32'd3, 4'd0, 32'd3, 4'd0, 32'h4000, 32'h8);
    drive_cdb(4'd11, 32'd5);
    exp_q.push_back(mk_exp(4'd7, 3'b011, 32'd5, 32'd5, 32'hFFFF_FFFC, 32'h10));
    exp_q.push_back(mk_exp(4'd5, 3'b101, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h2000, 32'h10));
    exp_q.push_back(mk_exp(4'd12, 3'b111, 32'd3, 32'd3, 32'h4000, 32'h8));
    step();
    idle();
    drive_cdb(4'd9, 32'hFFFF_FFFE);
    step();
    idle();
    wait_drain(8, left);
    n_checks++;
    if (left !== 0) begin
      n_fail++;
      $display("FAIL age_drain: got %0d pending, required 0", left);
    end
  endtask

  task automatic test_insert_bypass();
    drive_ins(3'b001, 4'd13, 32'd1, 4'd0, 32'hDEAD, 4'd14, 32'h500, 32'h100);
    drive_cdb(4'd14, 32'd2);
    exp_q.push_back(mk_exp(4'd13, 3'b001, 32'd1, 32'd2, 32'h500, 32'h100));
    step();
    idle();
    n_checks++;
    if (br_vk !== 32'd2 || br_op !== {3'b001, 7'h63}) begin
      n_fail++;
      $display("FAIL bypass_value: got br_vk=%h br_op=%h, required 00000002/%h", br_vk, br_op, {3'b001, 7'h63});
    end
    step();
    n_checks++;
    if (out_valid !== 1'b1 || out_tag !== 4'd13) begin
      n_fail++;
      $display("FAIL bypass_dispatch: got valid=%b tag=%0d, required 1/13", out_valid, out_tag);
    end
  endtask

  task automatic test_back_to_back();
    int left;
    for (int n = 0; n < 20; n++) begin
      logic [2:0]  f3;
      logic [31:0] vj, vk, pc, imm;
      logic [TAG_W-1:0] tag;
      f3  = 3'($urandom_range(0, 7));
      vj  = 32'($urandom_range(0, 3)) - 32'd2;
      vk  = 32'($urandom_range(0, 3)) - 32'd2;
      pc  = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      imm = {{20{1'b1}}, 12'($urandom_range(0, 4095))} ^ {$urandom_range(0, 1) == 1 ? 32'h0 : 32'hFFFF_F000};
      tag = TAG_W'((n % 15) + 1);
      drive_ins(f3, tag, vj, 4'd0, vk, 4'd0, pc, imm);
      exp_q.push_back(mk_exp(tag, f3, vj, vk, pc, imm));
      step();
      if (n > 0) begin
        n_checks++;
        if (out_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_throughput[%0d]: got out_valid=%b required 1", n, out_valid);
        end
      end
    end
    idle();
    wait_drain(5, left);
    n_checks++;
    if (left !== 0) begin
      n_fail++;
      $display("FAIL b2b_drain: got %0d pending, required 0", left);
    end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 3; k++) begin
      drive_ins(3'b000, TAG_W'(k + 1), 32'd0, 4'd9, 32'h77, 4'd0, 32'h600, 32'h4);
      if (k == 2) drive_cdb(4'd9, 32'h77);
      step();
    end
    idle();
    n_checks++;
    if (br_vj !== 32'h77) begin
      n_fail++;
      $display("FAIL flush_armed: got br_vj=%h required 00000077", br_vj);
    end
    flush = 1'b1;
    drive_ins(3'b000, 4'd4, 32'd1, 4'd0, 32'd1, 4'd0, 32'h700, 32'h4);
    step();
    idle();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || br_op !== 10'd0) begin
      n_fail++;
      $display("FAIL flush_state: got valid=%b in_ready=%b br_op=%h, required 0/1/0",
               out_valid, in_ready, br_op);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_quiet[%0d]: got out_valid=%b required 0", c, out_valid);
      end
    end
    // Four pending inserts must all fit, proving the station was emptied.
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL flush_occupancy[%0d]: got in_ready=%b required 1", k, in_ready);
      end
      drive_ins(3'b000, TAG_W'(k + 5), 32'd0, 4'd10, 32'd1, 4'd0, 32'h800, 32'h4);
      step();
    end
    idle();
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL refill_full: got in_ready=%b required 0", in_ready);
    end
  endtask

  task automatic test_reset_midstream();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++;
    if ({out_valid, out_tag, out_taken, out_target} !== '0 || in_ready !== 1'b1 || br_op !== 10'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got out=%h in_ready=%b br_op=%h, required 0/1/0",
               {out_valid, out_tag, out_taken, out_target}, in_ready, br_op);
    end
    drive_cdb(4'd10, 32'd1);
    step();
    idle();
    for (int c = 0; c < 4; c++) begin
      step();
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL midreset_quiet[%0d]: got out_valid=%b required 0", c, out_valid);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    idle();
    test_reset();
    test_beq_ready();
    test_blt_wakeup();
    test_age_order();
    test_insert_bypass();
    test_back_to_back();
    test_flush();
    test_reset_midstream();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL final_queue: got %0d pending results, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
